dpll_lock_detect: RTL and testbench

//  Consumer-side monitor for the DPLL: compares the recovered dpllOutput with the reference

---
 rtl/dpll_lock_detect.sv | 204 ++++++++++++++++++++
 tb/tb_dpll_lock_detect.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpll_lock_detect.sv
// dpll_lock_detect: watches a recovered DPLL clock against its reference.
// Measures the reference period and the folded phase error of the DPLL edge
// inside it, then reports lock, loss of lock and loss of reference.
module dpll_lock_detect #(
  parameter int CNT_W        = 16,
  parameter int LOCK_TOL     = 4,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 60000
) (
  input  logic             baseClockInput,
  input  logic             resetNInput,
  input  logic             enable,
  input  logic             oscInput,
  input  logic             dpllOutput,
  output logic             locked,
  output logic             lossOfRef,
  output logic             errValid,
  output logic [CNT_W-1:0] phaseError,
  output logic [CNT_W-1:0] refPeriod
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_NOREF   = 2'd3;

  localparam int HIT_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(REF_TIMEOUT);
  localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W+1)'(LOCK_TOL);

  // [1:0] is the two-flop synchronizer, [2] the previous value for edge detect
  logic [2:0]       ref_sync_q, dpll_sync_q;
  logic             ref_edge_q, dpll_edge_q;
  logic [CNT_W-1:0] since_ref_q;
  logic [CNT_W-1:0] t_cap_q;
  logic [1:0]       dpll_cnt_q;
  logic [1:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             locked_q, lossofref_q, err_valid_q;
  logic [CNT_W-1:0] phase_err_q, ref_period_q;

  logic [CNT_W:0]   p_ext, t_ext, rem_ext, err_ext;
  logic             single_edge, hit, ref_timeout, eval_en;

  // Synchronize both asynchronous inputs and register their rising edges
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge baseClockInput or negedge resetNInput) begin
    if (!resetNInput) begin
      ref_sync_q  <= '0;
      dpll_sync_q <= '0;
      ref_edge_q  <= 1'b0;
      dpll_edge_q <= 1'b0;
    end else begin
      ref_sync_q  <= {ref_sync_q[1:0], oscInput};
      dpll_sync_q <= {dpll_sync_q[1:0], dpllOutput};
      ref_edge_q  <= ref_sync_q[1] & ~ref_sync_q[2];
      dpll_edge_q <= dpll_sync_q[1] & ~dpll_sync_q[2];
    end
  end

  // Reference-relative time base and capture of the DPLL edge position
  always_ff @(posedge baseClockInput or negedge resetNInput) begin
    if (!resetNInput) begin
      since_ref_q <= '0;
      t_cap_q     <= '0;
      dpll_cnt_q  <= '0;
    end else begin
      if (ref_edge_q) begin
        since_ref_q <= CNT_ONE;
      end else if (since_ref_q != '1) begin
        since_ref_q <= since_ref_q + CNT_ONE;
      end
      // A DPLL edge coinciding with the reference edge opens the new period
      if (ref_edge_q) begin
        dpll_cnt_q <= dpll_edge_q ? 2'd1 : 2'd0;
        if (dpll_edge_q) t_cap_q <= '0;
      end else if (dpll_edge_q) begin
        t_cap_q <= since_ref_q;
        if (dpll_cnt_q != 2'd3) dpll_cnt_q <= dpll_cnt_q + 2'd1;
      end
    end
  end

  // Folded phase error of the period that closes on this reference edge
  always_comb begin
    p_ext       = {1'b0, since_ref_q};
    t_ext       = {1'b0, t_cap_q};
    rem_ext     = p_ext - t_ext;
    err_ext     = (t_ext <= rem_ext) ? t_ext : rem_ext;
    single_edge = (dpll_cnt_q == 2'd1);
    hit         = single_edge && (err_ext <= TOL_EXT);
    // A reference edge this cycle proves the reference is still alive
    ref_timeout = (since_ref_q >= CNT_TIMEOUT) && !ref_edge_q;
  end

  // Lock FSM: enable dominates, then reference timeout, then evaluation
  // NOTE: each output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    eval_en    = 1'b0;
    if (!enable) begin
      state_d    = ST_IDLE;
      armed_d    = 1'b0;
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end else if (state_q != ST_IDLE && ref_timeout) begin
      state_d = ST_NOREF;
      armed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQUIRE;
          armed_d    = 1'b0;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end
        ST_NOREF: begin
          // This edge is not evaluated; it opens the first measured period
          if (ref_edge_q) begin
            state_d    = ST_ACQUIRE;
            armed_d    = 1'b1;
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
          end
        end
        default: begin
          if (ref_edge_q) begin
            if (!armed_q) begin
              armed_d = 1'b1;
            end else begin
              eval_en = 1'b1;
              if (state_q == ST_ACQUIRE) begin
                if (!hit) begin
                  hit_cnt_d = '0;
                end else if (hit_cnt_q == HIT_W'(LOCK_COUNT - 1)) begin
                  state_d    = ST_LOCKED;
                  hit_cnt_d  = '0;
                  miss_cnt_d = '0;
                end else begin
                  hit_cnt_d = hit_cnt_q + HIT_W'(1);
                end
              end else begin
                if (hit) begin
                  miss_cnt_d = '0;
                end else if (miss_cnt_q == MISS_W'(UNLOCK_COUNT - 1)) begin
                  state_d    = ST_ACQUIRE;
                  hit_cnt_d  = '0;
                  miss_cnt_d = '0;
                end else begin
                  miss_cnt_d = miss_cnt_q + MISS_W'(1);
                end
              end
            end
          end
        end
      endcase
    end
  end

  // State registers plus registered status and measurement outputs
  always_ff @(posedge baseClockInput or negedge resetNInput) begin
    if (!resetNInput) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      locked_q     <= 1'b0;
      lossofref_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      phase_err_q  <= '0;
      ref_period_q <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= (state_d == ST_LOCKED);
      lossofref_q <= (state_d == ST_NOREF);
      err_valid_q <= eval_en;
      if (eval_en) begin
        phase_err_q  <= single_edge ? err_ext[CNT_W-1:0] : '1;
        ref_period_q <= since_ref_q;
      end
    end
  end

  assign locked     = locked_q;
  assign lossOfRef  = lossofref_q;
  assign errValid   = err_valid_q;
  assign phaseError = phase_err_q;
  assign refPeriod  = ref_period_q;

endmodule

// File: tb/tb_dpll_lock_detect.sv
// Bench for dpll_lock_detect: drives reference/DPLL waveforms period by
// period and predicts every evaluation from edge times in input cycles.
module tb_dpll_lock_detect;

  localparam int CNT_W        = 16;
  localparam int LOCK_TOL     = 4;
  localparam int LOCK_COUNT   = 8;
  localparam int UNLOCK_COUNT = 4;
  localparam int REF_TIMEOUT  = 60000;

  logic clk = 1'b0;
  logic rst_n, enable, osc, dpll;
  logic locked, lossOfRef, errValid;
  logic [CNT_W-1:0] phaseError, refPeriod;

  dpll_lock_detect #(
    .CNT_W(CNT_W), .LOCK_TOL(LOCK_TOL), .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT), .REF_TIMEOUT(REF_TIMEOUT)
  ) dut (
    .baseClockInput(clk),
    .resetNInput(rst_n),
    .enable(enable),
    .oscInput(osc),
    .dpllOutput(dpll),
    .locked(locked),
    .lossOfRef(lossOfRef),
    .errValid(errValid),
    .phaseError(phaseError),
    .refPeriod(refPeriod)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: tracks the lock decision from period-level quantities
  typedef enum {M_IDLE, M_ACQ, M_LOCK, M_NOREF} mstate_e;
  typedef struct {
    logic [15:0] err;
    logic [15:0] per;
    logic        lk;
  } exp_t;

  exp_t    exp_q[$];
  mstate_e m_state = M_IDLE;
  bit      m_armed = 1'b0;
  int      m_hits = 0, m_misses = 0;
  int      m_gap = 0;
  int      m_prev_n = 0, m_prev_lag = 0;

  task automatic model_ref_edge(input int gap);
    if (m_state == M_IDLE) return;
    if (gap > REF_TIMEOUT) m_state = M_NOREF;
    if (m_state == M_NOREF) begin
      m_state = M_ACQ; m_armed = 1'b1; m_hits = 0; m_misses = 0;
    end else if (!m_armed) begin
      m_armed = 1'b1;
    end else begin
      exp_t e;
      int   err;
      bit   hit;
      if (m_prev_n == 1) begin
        err   = (m_prev_lag < gap - m_prev_lag) ? m_prev_lag : gap - m_prev_lag;
        hit   = (err <= LOCK_TOL);
        e.err = err[15:0];
      end else begin
        hit   = 1'b0;
        e.err = 16'hFFFF;
      end
      e.per = gap[15:0];
      if (m_state == M_ACQ) begin
        m_hits = hit ? m_hits + 1 : 0;
        if (m_hits == LOCK_COUNT) begin m_state = M_LOCK; m_misses = 0; end
      end else begin
        m_misses = hit ? 0 : m_misses + 1;
        if (m_misses == UNLOCK_COUNT) begin m_state = M_ACQ; m_hits = 0; end
      end
      e.lk = (m_state == M_LOCK);
      exp_q.push_back(e);
    end
  endtask

  // One reference period of p cycles; n DPLL pulses at lags l0 (and l1)
  task automatic drive_period(input int p, input int n, input int l0, input int l1);
    model_ref_edge(m_gap);
    m_gap = 0; m_prev_n = n; m_prev_lag = l0;
    for (int c = 0; c < p; c++) begin
      @(negedge clk);
      osc  = (c < 2);
      dpll = (n > 0 && c >= l0 && c < l0 + 2) || (n > 1 && c >= l1 && c < l1 + 2);
      m_gap++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      osc = 1'b0; dpll = 1'b0;
      m_gap++;
      if (m_gap > REF_TIMEOUT && (m_state == M_ACQ || m_state == M_LOCK)) begin
        m_state = M_NOREF; m_armed = 1'b0;
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_locked"}, locked, m_state == M_LOCK);
    check({tag, "_lossOfRef"}, lossOfRef, m_state == M_NOREF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_lossOfRef"}, lossOfRef, 0);
    check({tag, "_errValid"}, errValid, 0);
    check({tag, "_phaseError"}, phaseError, 0);
    check({tag, "_refPeriod"}, refPeriod, 0);
  endtask

  // Every errValid pulse must match the oldest predicted evaluation
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && errValid) begin
        if (exp_q.size() == 0) begin
          check("spurious_errValid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("phaseError", phaseError, e.err);
          check("refPeriod", refPeriod, e.per);
          check("locked_at_errValid", locked, e.lk);
          check("lossOfRef_at_errValid", lossOfRef, 0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b0; osc = 1'b0; dpll = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    m_state = M_ACQ; m_armed = 1'b0; m_hits = 0; m_misses = 0;
    idle_cycles(4);

    // Acquire with a 2-cycle lag
    repeat (10) drive_period(100, 1, 2, 0);
    check_status("lock_lag2");

    // Lag steps to 30: four misses drop lock; lag 97 folds to 3 and relocks
    repeat (5) drive_period(100, 1, 30, 0);
    check_status("unlock_lag30");
    repeat (9) drive_period(100, 1, 97, 0);
    check_status("relock_lag97");

    // Two DPLL edges, none, then coincident edges
    drive_period(100, 2, 10, 50);
    drive_period(100, 0, 0, 0);
    drive_period(100, 1, 0, 0);
    drive_period(100, 1, 0, 0);
    drive_period(100, 2, 5, 60);
    repeat (10) drive_period(100, 1, 0, 0);
    check_status("lock_lag0");

    // Randomized periods and lags, biased towards near-hits
    for (int i = 0; i < 40; i++) begin
      int p, sel, l0, l1, n;
      p   = int'($urandom_range(20, 150));
      sel = int'($urandom_range(0, 9));
      n = 1; l1 = 0;
      if (sel <= 5)      l0 = int'($urandom_range(0, 5));
      else if (sel <= 7) l0 = p - 3 - int'($urandom_range(0, 3));
      else if (sel == 8) begin
        n  = 2;
        l0 = int'($urandom_range(0, p / 2 - 3));
        l1 = int'($urandom_range(l0 + 3, p - 3));
      end else begin
        n  = int'($urandom_range(0, 1));
        l0 = int'($urandom_range(0, p - 3));
      end
      drive_period(p, n, l0, l1);
    end
    check_status("random_end");

    // Lose the reference while locked, then resume and relock
    repeat (10) drive_period(100, 1, 1, 0);
    check_status("pre_timeout");
    idle_cycles(REF_TIMEOUT + 100);
    check_status("timeout");
    repeat (10) drive_period(100, 1, 3, 0);
    check_status("relock_after_noref");

    // Drop enable while locked
    @(negedge clk);
    enable = 1'b0;
    m_state = M_IDLE; m_armed = 1'b0; m_hits = 0; m_misses = 0;
    m_gap++;
    idle_cycles(1);
    check_status("enable_low");
    idle_cycles(3);
    enable = 1'b1;
    m_state = M_ACQ;
    repeat (10) drive_period(100, 1, 2, 0);
    check_status("relock_after_enable");

    // Asynchronous reset in the middle of a period
    idle_cycles(30);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    m_state = M_IDLE; m_armed = 1'b0; m_hits = 0; m_misses = 0;
    idle_cycles(3);
    rst_n = 1'b1;
    m_state = M_ACQ;
    idle_cycles(5);
    repeat (10) drive_period(100, 1, 4, 0);
    check_status("relock_after_reset");

    idle_cycles(20);
    check("pending_evaluations", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
